reg_writeback_ctrl: RTL and testbench

- Write-side initiator for the 16x16 register file; the file is the responder.
- Accepts execute/mul-div results over a valid/ready handshake and queues them in a DEPTH-entry FIFO.
- Drains at most one entry per cycle onto the register-file write port: 2-bit write-enable, Rd address/data, R0 data.
- Reports per-register pending-write status to the decode stage so reads of not-yet-written registers can stall.

---
 rtl/reg_writeback_ctrl_pkg.sv | 32 +++
 rtl/reg_writeback_ctrl_wb_entry_fifo.sv | 70 +++++++
 rtl/reg_writeback_ctrl.sv | 99 +++++++++
 tb/tb_reg_writeback_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_writeback_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_writeback_ctrl_pkg
// Description : Shared types and constants for the register write-back path.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_writeback_ctrl_pkg;

    localparam int REG_W  = 16;
    localparam int REG_AW = 4;

    localparam logic [1:0]        REGW_NONE = 2'b00;
    localparam logic [1:0]        REGW_RD   = 2'b01;
    localparam logic [1:0]        REGW_R0   = 2'b10;
    localparam logic [1:0]        REGW_BOTH = 2'b11;
    localparam logic [REG_AW-1:0] R0_ADDR   = 4'h0;

    typedef struct packed {
        logic              weRd;
        logic              weR0;
        logic [REG_AW-1:0] dest;
        logic [REG_W-1:0]  data;
        logic [REG_W-1:0]  r0Data;
    } wbEntry_t;

    // True when entry e will write the register at address a.
    function automatic logic hitsAddr(input wbEntry_t e, input logic [REG_AW-1:0] a);
        return (e.weRd && (e.dest == a)) || (e.weR0 && (a == R0_ADDR));
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_writeback_ctrl_wb_entry_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_entry_fifo
// Description : Write-back entry FIFO exposing every slot and its valid bit.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_entry_fifo
    import reg_writeback_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_push,
    input  wbEntry_t              i_pushEntry,
    input  logic                  i_pop,
    output wbEntry_t              o_head,
    output wbEntry_t [DEPTH-1:0]  o_entries,
    output logic     [DEPTH-1:0]  o_valid,
    output logic                  o_full,
    output logic                  o_empty
);

    wbEntry_t [DEPTH-1:0] r_mem;
    logic     [DEPTH-1:0] r_valid;
    logic     [AW-1:0]    r_wrPtr;
    logic     [AW-1:0]    r_rdPtr;
    logic     [AW:0]      r_count;

    logic w_doPush;
    logic w_doPop;

    assign o_full   = (r_count == (AW+1)'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem   <= '0;
            r_valid <= '0;
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_mem[r_wrPtr]   <= i_pushEntry;
                r_valid[r_wrPtr] <= 1'b1;
                r_wrPtr          <= r_wrPtr + AW'(1);
            end
            // Push and pop never share a slot: that needs empty-and-full at once.
            if (w_doPop) begin
                r_valid[r_rdPtr] <= 1'b0;
                r_rdPtr          <= r_rdPtr + AW'(1);
            end
            if (w_doPush && !w_doPop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (!w_doPush && w_doPop) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

    assign o_head    = r_mem[r_rdPtr];
    assign o_entries = r_mem;
    assign o_valid   = r_valid;

endmodule
`default_nettype wire

// File: rtl/reg_writeback_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : reg_writeback_ctrl
// Description : Queues results and drains them onto the register-file write port.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_writeback_ctrl
    import reg_writeback_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic              wb_we_rd,
    input  logic              wb_we_r0,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic [REG_W-1:0]  wb_data,
    input  logic [REG_W-1:0]  wb_r0_data,
    input  logic              wr_enable,
    output logic [1:0]        registerWrite,
    output logic [REG_AW-1:0] regWriteLocal,
    output logic [REG_W-1:0]  dataWrite,
    output logic [REG_W-1:0]  r0Write,
    input  logic [REG_AW-1:0] query_addr1,
    input  logic [REG_AW-1:0] query_addr2,
    output logic              pending1,
    output logic              pending2,
    output logic              empty
);

    wbEntry_t             w_pushEntry;
    wbEntry_t             w_head;
    wbEntry_t [DEPTH-1:0] w_entries;
    logic     [DEPTH-1:0] w_valid;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_active;
    logic     [DEPTH-1:0] w_hit1;
    logic     [DEPTH-1:0] w_hit2;

    assign w_pushEntry = '{weRd: wb_we_rd, weR0: wb_we_r0, dest: wb_dest,
                           data: wb_data, r0Data: wb_r0_data};
    // Results that write nothing are acknowledged but never stored.
    assign w_push   = wb_valid && !w_full && (wb_we_rd || wb_we_r0);
    assign w_active = !w_empty && wr_enable;

    wb_entry_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (w_push),
        .i_pushEntry (w_pushEntry),
        .i_pop       (w_active),
        .o_head      (w_head),
        .o_entries   (w_entries),
        .o_valid     (w_valid),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign wb_ready = !w_full;
    assign empty    = w_empty;

    always_comb begin
        registerWrite = REGW_NONE;
        regWriteLocal = '0;
        dataWrite     = '0;
        r0Write       = '0;
        if (!w_empty) begin
            regWriteLocal = w_head.dest;
            dataWrite     = w_head.data;
            r0Write       = w_head.r0Data;
        end
        if (w_active) begin
            // Rd and R0 targeting the same register: the Rd result wins.
            if (w_head.weRd && w_head.weR0 && (w_head.dest == R0_ADDR)) begin
                registerWrite = REGW_RD;
            end else begin
                registerWrite = {w_head.weR0, w_head.weRd};
            end
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_pend
        assign w_hit1[i] = w_valid[i] && hitsAddr(w_entries[i], query_addr1);
        assign w_hit2[i] = w_valid[i] && hitsAddr(w_entries[i], query_addr2);
    end

    assign pending1 = |w_hit1;
    assign pending2 = |w_hit2;

endmodule
`default_nettype wire

// File: tb/tb_reg_writeback_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_writeback_ctrl
// Description : Directed self-checking bench for reg_writeback_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_writeback_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wb_valid;
    logic        wb_ready;
    logic        wb_we_rd;
    logic        wb_we_r0;
    logic [3:0]  wb_dest;
    logic [15:0] wb_data;
    logic [15:0] wb_r0_data;
    logic        wr_enable;
    logic [1:0]  registerWrite;
    logic [3:0]  regWriteLocal;
    logic [15:0] dataWrite;
    logic [15:0] r0Write;
    logic [3:0]  query_addr1;
    logic [3:0]  query_addr2;
    logic        pending1;
    logic        pending2;
    logic        empty;

    int r_total  = 0;
    int r_passed = 0;

    reg_writeback_ctrl #(
        .DEPTH (4),
        .AW    (2)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_we_rd      (wb_we_rd),
        .wb_we_r0      (wb_we_r0),
        .wb_dest       (wb_dest),
        .wb_data       (wb_data),
        .wb_r0_data    (wb_r0_data),
        .wr_enable     (wr_enable),
        .registerWrite (registerWrite),
        .regWriteLocal (regWriteLocal),
        .dataWrite     (dataWrite),
        .r0Write       (r0Write),
        .query_addr1   (query_addr1),
        .query_addr2   (query_addr2),
        .pending1      (pending1),
        .pending2      (pending2),
        .empty         (empty)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        r_total++;
        assert (obs === exp) r_passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic rd, input logic r0, input logic [3:0] d,
                         input logic [15:0] dat, input logic [15:0] r0d);
        wb_valid   = 1'b1;
        wb_we_rd   = rd;
        wb_we_r0   = r0;
        wb_dest    = d;
        wb_data    = dat;
        wb_r0_data = r0d;
    endtask

    initial begin
        int k;
        reset_n     = 1'b0;
        wb_valid    = 1'b0;
        wb_we_rd    = 1'b0;
        wb_we_r0    = 1'b0;
        wb_dest     = 4'h0;
        wb_data     = 16'h0;
        wb_r0_data  = 16'h0;
        wr_enable   = 1'b0;
        query_addr1 = 4'h0;
        query_addr2 = 4'h0;
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // Reset / idle
        #1;
        chk("rst_regw",  32'(registerWrite), 32'h0);
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_ready", 32'(wb_ready), 32'h1);
        chk("rst_pend1", 32'(pending1), 32'h0);
        chk("rst_pend2", 32'(pending2), 32'h0);
        chk("rst_data",  32'(dataWrite), 32'h0);

        // Single Rd write
        wr_enable = 1'b1;
        offer(1'b1, 1'b0, 4'd5, 16'h1234, 16'h0);
        tick();
        wb_valid = 1'b0;
        #1;
        chk("rd_regw", 32'(registerWrite), 32'h1);
        chk("rd_addr", 32'(regWriteLocal), 32'h5);
        chk("rd_data", 32'(dataWrite), 32'h1234);
        chk("rd_notempty", 32'(empty), 32'h0);
        tick();
        #1;
        chk("rd_empty_after", 32'(empty), 32'h1);
        chk("rd_regw_after", 32'(registerWrite), 32'h0);

        // Mul result writing Rd and R0
        offer(1'b1, 1'b1, 4'd3, 16'h5678, 16'h0009);
        tick();
        wb_valid = 1'b0;
        #1;
        chk("mul_regw", 32'(registerWrite), 32'h3);
        chk("mul_r0",   32'(r0Write), 32'h0009);
        chk("mul_data", 32'(dataWrite), 32'h5678);
        tick();

        // Collision: Rd is R0
        offer(1'b1, 1'b1, 4'd0, 16'h5678, 16'h0009);
        tick();
        wb_valid = 1'b0;
        #1;
        chk("coll_regw", 32'(registerWrite), 32'h1);
        chk("coll_data", 32'(dataWrite), 32'h5678);
        tick();
        #1;
        chk("coll_empty", 32'(empty), 32'h1);

        // Enables both low: dropped
        offer(1'b0, 1'b0, 4'd6, 16'hDEAD, 16'hBEEF);
        tick();
        wb_valid = 1'b0;
        #1;
        chk("drop_empty", 32'(empty), 32'h1);
        chk("drop_regw",  32'(registerWrite), 32'h0);

        // Fill with drain frozen; fifth is refused
        wr_enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            offer(1'b1, 1'b0, 4'(i + 1), 16'hA000 + 16'(i), 16'h0);
            #1;
            chk("fill_ready", 32'(wb_ready), (i < 4) ? 32'h1 : 32'h0);
            tick();
        end
        wb_valid = 1'b0;
        query_addr1 = 4'd3;
        query_addr2 = 4'd0;
        #1;
        chk("frz_regw",  32'(registerWrite), 32'h0);
        chk("frz_addr",  32'(regWriteLocal), 32'h1);
        chk("frz_pend1", 32'(pending1), 32'h1);
        chk("frz_pend2", 32'(pending2), 32'h0);
        query_addr1 = 4'd5;
        #1;
        chk("frz_pend_fifth", 32'(pending1), 32'h0);
        wr_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_regw", 32'(registerWrite), 32'h1);
            chk("drain_addr", 32'(regWriteLocal), 32'(i + 1));
            chk("drain_data", 32'(dataWrite), 32'hA000 + 32'(i));
            tick();
        end
        #1;
        chk("drain_empty", 32'(empty), 32'h1);

        // Pending tracking for Rd and R0-only writes
        wr_enable = 1'b0;
        offer(1'b1, 1'b0, 4'd7, 16'h0077, 16'h0);
        tick();
        offer(1'b0, 1'b1, 4'd9, 16'h0, 16'h00AA);
        tick();
        wb_valid = 1'b0;
        query_addr1 = 4'd7;
        query_addr2 = 4'd9;
        #1;
        chk("pend_r0only_dest", 32'(pending2), 32'h0);
        query_addr2 = 4'd0;
        #1;
        chk("pend1_q", 32'(pending1), 32'h1);
        chk("pend2_q", 32'(pending2), 32'h1);
        wr_enable = 1'b1;
        #1;
        chk("pend_head_regw", 32'(registerWrite), 32'h1);
        chk("pend1_head", 32'(pending1), 32'h1);
        tick();
        #1;
        chk("pend1_popped", 32'(pending1), 32'h0);
        chk("pend2_still",  32'(pending2), 32'h1);
        chk("r0only_regw",  32'(registerWrite), 32'h2);
        chk("r0only_data",  32'(r0Write), 32'h00AA);
        tick();
        #1;
        chk("pend2_popped", 32'(pending2), 32'h0);
        query_addr1 = 4'd8;
        #1;
        chk("pend_q8", 32'(pending1), 32'h0);

        // Full FIFO, drain and refill continuously
        wr_enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            offer(1'b1, 1'b0, 4'(8 + i), 16'hB000 + 16'(i), 16'h0);
            tick();
        end
        k = 4;
        offer(1'b1, 1'b0, 4'hC, 16'hB004, 16'h0);
        wr_enable = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("flow_ready", 32'(wb_ready), (c == 0) ? 32'h0 : 32'h1);
            chk("flow_data",  32'(dataWrite), 32'hB000 + 32'(c));
            chk("flow_regw",  32'(registerWrite), 32'h1);
            if (c > 0) k++;
            tick();
            wb_data = 16'hB000 + 16'(k);
        end
        wb_valid = 1'b0;
        // Entries B008..B00A remain (B004..B00B offered while ready, k ended at 11)
        for (int c = 8; c < 11; c++) begin
            #1;
            chk("tail_data", 32'(dataWrite), 32'hB000 + 32'(c));
            tick();
        end
        #1;
        chk("flow_empty", 32'(empty), 32'h1);

        // Reset mid-drain
        wr_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(1'b1, 1'b0, 4'(i + 2), 16'hC000 + 16'(i), 16'h0);
            tick();
        end
        wb_valid  = 1'b0;
        wr_enable = 1'b1;
        #1;
        chk("mid_regw_pre", 32'(registerWrite), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("mid_regw", 32'(registerWrite), 32'h0);
        chk("mid_data", 32'(dataWrite), 32'h0);
        chk("mid_addr", 32'(regWriteLocal), 32'h0);
        chk("mid_empty", 32'(empty), 32'h1);
        chk("mid_ready", 32'(wb_ready), 32'h1);
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("post_rst_regw", 32'(registerWrite), 32'h0);
        end

        $display("%0d/%0d checks passed", r_passed, r_total);
        $finish;
    end

endmodule
`default_nettype wire
